writeback: RTL and testbench

//   Final stage of the TinyRisc-V core, downstream of the memory stage.

---
 rtl/writeback.sv | 240 ++++++++++++++++++++++++
 tb/tb_writeback.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/writeback.sv
// Writeback stage of the TinyRisc-V core: waits on the memory stage for loads/stores,
// commits the selected result to the integer register file it owns and counts retirements.
module writeback #(
    parameter int XLEN      = 32,
    parameter int INSTRET_W = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [6:0]           opcode,
    input  logic [4:0]           rd,
    input  logic [XLEN-1:0]      alu_out,
    input  logic [XLEN-1:0]      pc_plus4,
    input  logic [XLEN-1:0]      rdata,
    input  logic                 mem_done,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [XLEN-1:0]      rs1_data,
    output logic [XLEN-1:0]      rs2_data,
    output logic                 busy,
    output logic                 commit,
    output logic                 illegal,
    output logic [INSTRET_W-1:0] instret
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_LOAD = 2'd1,
        SEL_LINK = 2'd2,
        SEL_ALU  = 2'd3
    } wb_sel_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    function automatic wb_sel_t decode_sel(input logic [6:0] op);
        wb_sel_t sel;
        case (op)
            OP_LOAD:                         sel = SEL_LOAD;
            OP_JAL, OP_JALR:                 sel = SEL_LINK;
            OP_LUI, OP_AUIPC, OP_IMM, OP_OP: sel = SEL_ALU;
            default:                         sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic is_legal(input logic [6:0] op);
        logic legal;
        case (op)
            OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR,
            OP_LUI, OP_AUIPC, OP_IMM, OP_OP: legal = 1'b1;
            default:                         legal = 1'b0;
        endcase
        return legal;
    endfunction

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [6:0]             opcode_r;
    logic [4:0]             rd_r;
    logic [XLEN-1:0]        alu_out_r;
    logic [XLEN-1:0]        pc_plus4_r;
    logic [XLEN-1:0]        rdata_r;
    logic                   busy_r;
    logic                   commit_r;
    logic                   illegal_r;
    logic                   illegal_nxt_s;
    logic [INSTRET_W-1:0]   instret_r;
    logic [XLEN-1:0]        regs_r [0:31];
    wb_sel_t                sel_s;
    logic                   wr_en_s;
    logic [XLEN-1:0]        wdata_s;
    logic [XLEN-1:0]        rs1_data_s;
    logic [XLEN-1:0]        rs2_data_s;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the illegal flag of the instruction about to commit
    always_comb begin
        state_nxt_s   = state_r;
        illegal_nxt_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    if (is_mem_op(opcode)) begin
                        state_nxt_s = WAIT_MEM;
                    end else begin
                        state_nxt_s   = COMMIT;
                        illegal_nxt_s = !is_legal(opcode);
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT_MEM: begin
                // Only LOAD/STORE reach this state, so the retiring op is always legal.
                if (mem_done) begin
                    state_nxt_s = COMMIT;
                end else begin
                    state_nxt_s = WAIT_MEM;
                end
            end
            COMMIT:  state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // Instruction operand capture on issue and load data capture on memory completion
    always_ff @(posedge clk) begin
        if (rst) begin
            opcode_r   <= 7'd0;
            rd_r       <= 5'd0;
            alu_out_r  <= {XLEN{1'b0}};
            pc_plus4_r <= {XLEN{1'b0}};
            rdata_r    <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        opcode_r   <= opcode;
                        rd_r       <= rd;
                        alu_out_r  <= alu_out;
                        pc_plus4_r <= pc_plus4;
                    end
                end
                WAIT_MEM: begin
                    if (mem_done) begin
                        rdata_r <= rdata;
                    end
                end
                default: begin
                    rdata_r <= rdata_r;
                end
            endcase
        end
    end

    // Registered status outputs, computed one cycle ahead from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            commit_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            busy_r    <= (state_nxt_s != IDLE);
            commit_r  <= (state_nxt_s == COMMIT);
            illegal_r <= illegal_nxt_s;
        end
    end

    // Write-back select and enable for the committing instruction
    always_comb begin
        sel_s   = decode_sel(opcode_r);
        wr_en_s = 1'b0;
        wdata_s = {XLEN{1'b0}};
        case (sel_s)
            SEL_LOAD: wdata_s = rdata_r;
            SEL_LINK: wdata_s = pc_plus4_r;
            SEL_ALU:  wdata_s = alu_out_r;
            default:  wdata_s = {XLEN{1'b0}};
        endcase
        if ((state_r == COMMIT) && (rd_r != 5'd0) && (sel_s != SEL_NONE)) begin
            wr_en_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Integer register file; entry 0 is never written and never read out
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wr_en_s) begin
            regs_r[rd_r] <= wdata_s;
        end
    end

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (state_r == COMMIT) begin
            instret_r <= instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1};
        end
    end

    // Read ports with same-cycle forwarding of the value being written
    always_comb begin
        rs1_data_s = {XLEN{1'b0}};
        rs2_data_s = {XLEN{1'b0}};
        if (rs1_addr == 5'd0) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if (wr_en_s && (rs1_addr == rd_r)) begin
            rs1_data_s = wdata_s;
        end else begin
            rs1_data_s = regs_r[rs1_addr];
        end
        if (rs2_addr == 5'd0) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if (wr_en_s && (rs2_addr == rd_r)) begin
            rs2_data_s = wdata_s;
        end else begin
            rs2_data_s = regs_r[rs2_addr];
        end
    end

    assign rs1_data = rs1_data_s;
    assign rs2_data = rs2_data_s;
    assign busy     = busy_r;
    assign commit   = commit_r;
    assign illegal  = illegal_r;
    assign instret  = instret_r;

endmodule

// File: tb/tb_writeback.sv
// Directed bench for the writeback stage: issues hand-built instructions and
// compares status outputs, register contents and the retire counter against fixed values.
module tb_writeback;

    logic        clk;
    logic        rst;
    logic        start;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] alu_out;
    logic [31:0] pc_plus4;
    logic [31:0] rdata;
    logic        mem_done;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        busy;
    logic        commit;
    logic        illegal;
    logic [63:0] instret;

    int n_checks_r;
    int n_errors_r;

    writeback #(.XLEN(32), .INSTRET_W(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .opcode   (opcode),
        .rd       (rd),
        .alu_out  (alu_out),
        .pc_plus4 (pc_plus4),
        .rdata    (rdata),
        .mem_done (mem_done),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .busy     (busy),
        .commit   (commit),
        .illegal  (illegal),
        .instret  (instret)
    );

    // Free-running core clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks_r++;
        if (got !== exp) begin
            n_errors_r++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [6:0] op, input logic [4:0] d, input logic [31:0] alu,
                         input logic [31:0] pc4);
        start    = 1'b1;
        opcode   = op;
        rd       = d;
        alu_out  = alu;
        pc_plus4 = pc4;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [31:0] exp);
        rs1_addr = idx;
        #1;
        check_eq(tag, {32'd0, rs1_data}, {32'd0, exp});
    endtask

    // Directed stimulus
    initial begin
        n_checks_r = 0;
        n_errors_r = 0;
        rst = 1'b1; start = 1'b0; opcode = 7'd0; rd = 5'd0; alu_out = 32'd0;
        pc_plus4 = 32'd0; rdata = 32'd0; mem_done = 1'b0; rs1_addr = 5'd0; rs2_addr = 5'd0;
        tick(); tick();
        rst = 1'b0;
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_commit", {63'd0, commit}, 64'd0);
        check_eq("rst_illegal", {63'd0, illegal}, 64'd0);
        check_eq("rst_instret", instret, 64'd0);
        check_reg("rst_x5", 5'd5, 32'd0);

        // LUI x5: commit in the cycle after the start cycle, forwarded meanwhile
        issue(7'b0110111, 5'd5, 32'h12345000, 32'h0);
        check_eq("lui_commit", {63'd0, commit}, 64'd1);
        check_eq("lui_busy", {63'd0, busy}, 64'd1);
        check_eq("lui_illegal", {63'd0, illegal}, 64'd0);
        check_reg("lui_fwd_rs1", 5'd5, 32'h12345000);
        tick();
        check_eq("lui_commit_low", {63'd0, commit}, 64'd0);
        check_eq("lui_busy_low", {63'd0, busy}, 64'd0);
        check_reg("lui_x5", 5'd5, 32'h12345000);
        check_eq("lui_instret", instret, 64'd1);

        // LOAD x7 with mem_done in the third wait cycle; a stray start is ignored
        issue(7'b0000011, 5'd7, 32'hdeadbeef, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check_eq($sformatf("ld_wait_busy%0d", i), {63'd0, busy}, 64'd1);
            check_eq($sformatf("ld_wait_commit%0d", i), {63'd0, commit}, 64'd0);
            if (i == 0) begin
                start = 1'b1; opcode = 7'b0110111; rd = 5'd5; alu_out = 32'haaaaaaaa;
            end else begin
                start = 1'b0;
            end
            if (i == 2) begin
                mem_done = 1'b1; rdata = 32'hffffffde;
            end
            tick();
        end
        mem_done = 1'b0; rdata = 32'h0;
        check_eq("ld_commit", {63'd0, commit}, 64'd1);
        check_eq("ld_busy4", {63'd0, busy}, 64'd1);
        tick();
        check_eq("ld_busy_low", {63'd0, busy}, 64'd0);
        check_reg("ld_x7", 5'd7, 32'hffffffde);
        check_reg("ld_x5_kept", 5'd5, 32'h12345000);
        check_eq("ld_instret", instret, 64'd2);

        // mem_done while idle has no effect
        mem_done = 1'b1; rdata = 32'h55555555;
        tick();
        mem_done = 1'b0;
        check_eq("idle_done_busy", {63'd0, busy}, 64'd0);
        check_eq("idle_done_commit", {63'd0, commit}, 64'd0);

        // STORE then BRANCH: retire without writing
        issue(7'b0100011, 5'd5, 32'h11111111, 32'h0);
        mem_done = 1'b1; rdata = 32'h22222222;
        tick();
        mem_done = 1'b0;
        check_eq("st_commit", {63'd0, commit}, 64'd1);
        tick();
        issue(7'b1100011, 5'd7, 32'h33333333, 32'h44444444);
        check_eq("br_commit", {63'd0, commit}, 64'd1);
        tick();
        check_reg("stbr_x5", 5'd5, 32'h12345000);
        check_reg("stbr_x7", 5'd7, 32'hffffffde);
        check_eq("stbr_instret", instret, 64'd4);

        // JAL to x0 is discarded; JALR x1 is forwarded on rs2 during commit
        issue(7'b1101111, 5'd0, 32'h0, 32'h00000100);
        tick();
        check_reg("jal_x0", 5'd0, 32'd0);
        rs2_addr = 5'd1;
        issue(7'b1100111, 5'd1, 32'h2222, 32'h00000100);
        check_eq("jalr_fwd_rs2", {32'd0, rs2_data}, 64'h100);
        tick();
        check_reg("jalr_x1", 5'd1, 32'h00000100);
        check_eq("jalr_instret", instret, 64'd6);

        // Unknown opcode retires as illegal without a write
        issue(7'b1111111, 5'd3, 32'h3333, 32'h0);
        check_eq("ill_commit", {63'd0, commit}, 64'd1);
        check_eq("ill_flag", {63'd0, illegal}, 64'd1);
        tick();
        check_eq("ill_flag_low", {63'd0, illegal}, 64'd0);
        check_reg("ill_x3", 5'd3, 32'd0);
        check_eq("ill_instret", instret, 64'd7);

        // Reset while a LOAD x9 waits on memory abandons it
        issue(7'b0000011, 5'd9, 32'h0, 32'h0);
        check_eq("rstmid_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mem_done = 1'b1; rdata = 32'h99999999;
        tick();
        mem_done = 1'b0;
        check_eq("rstmid_commit", {63'd0, commit}, 64'd0);
        check_eq("rstmid_busy_low", {63'd0, busy}, 64'd0);
        tick();
        check_eq("rstmid_commit2", {63'd0, commit}, 64'd0);
        check_reg("rstmid_x9", 5'd9, 32'd0);
        check_reg("rstmid_x7", 5'd7, 32'd0);
        check_eq("rstmid_instret", instret, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks_r, n_errors_r);
        $finish;
    end

endmodule
